dlfloat_mac_host_link: RTL and testbench

Host-side link controller for the byte-serial DLFloat16 MAC pin interface. It accepts operand pairs (a, b) on a valid/ready request port. It drives them onto the MAC's 16-bit input bus in the two-phase A/B order the MAC's input wrapper expects. It then captures the MAC's alternating low/high result bytes, reassembles the 16-bit accumulator value and returns it on a valid/ready response port. It sits in the FPGA/host harness and in the top-level testbench, facing the tile pins.

---
 rtl/dlfloat_pkg.sv | 40 ++++
 rtl/dlfloat_mac_host_link_if.sv | 30 +++
 rtl/byte_deser.sv | 49 ++++
 rtl/dlfloat_mac_host_link.sv | 99 +++++++++
 tb/tb_dlfloat_mac_host_link.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants, link FSM encoding and operand-pair struct for the MAC host link.
// Pure declarations: no latency and no flow control of its own.
package dlfloat_pkg;

  localparam int DLF_W    = 16;
  localparam int EXP_W    = 6;
  localparam int MAN_W    = 9;
  localparam int EXP_BIAS = 31;

  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_ONE  = {1'b0, EXP_W'(EXP_BIAS), MAN_W'(0)};

  // Wait counter must hold WAIT_CYC-1 for the largest legal WAIT_CYC (63).
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT,
    ST_CAP_LO,
    ST_CAP_HI,
    ST_RESP
  } link_state_e;

  typedef struct packed {
    logic [DLF_W-1:0] a;
    logic [DLF_W-1:0] b;
  } dlf_pair_t;

  function automatic logic [DLF_W-1:0] dlf_join(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

  function automatic logic dlf_is_nan(input logic [DLF_W-1:0] x);
    return x == DLF_NAN;
  endfunction

endpackage

// File: rtl/dlfloat_mac_host_link_if.sv
// Request / response / pin bundle between the host harness (master) and the MAC link controller (slave).
// Wires only: no latency; request and response use valid/ready, pins are free-running.
interface dlfloat_mac_host_link_if;
  import dlfloat_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [DLF_W-1:0] req_a;
  logic [DLF_W-1:0] req_b;

  logic [DLF_W-1:0] pin_data;
  logic [7:0]       pin_byte;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [DLF_W-1:0] rsp_data;

  logic             phase;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, pin_byte,
    input  req_ready, pin_data, rsp_valid, rsp_data, phase
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, pin_byte,
    output req_ready, pin_data, rsp_valid, rsp_data, phase
  );

endinterface

// File: rtl/byte_deser.sv
// Phase-qualified capture of the MAC's low (phase 1) and high (phase 0) result bytes.
// One-cycle capture per byte; done pulses the cycle after the high byte lands; no backpressure.
module byte_deser
  import dlfloat_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             phase,
  input  logic             lo_en,
  input  logic             hi_en,
  input  logic [7:0]       pin_byte,
  output logic [DLF_W-1:0] word,
  output logic             done
);

  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic       done_q, done_d;

  // Enables are additionally gated by phase so a mistimed strobe cannot grab the wrong byte.
  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    done_d = 1'b0;
    if (lo_en && phase) begin
      lo_d = pin_byte;
    end
    if (hi_en && !phase) begin
      hi_d   = pin_byte;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q   <= 8'h00;
      hi_q   <= 8'h00;
      done_q <= 1'b0;
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      done_q <= done_d;
    end
  end

  assign word = dlf_join(hi_q, lo_q);
  assign done = done_q;

endmodule

// File: rtl/dlfloat_mac_host_link.sv
// Host-side link: serialises one (a,b) pair onto the MAC pins in A/B phase order and returns the 16-bit result.
// Accept-to-rsp_valid = WAIT_CYC+5 (+1 when WAIT_CYC is odd); one transaction in flight, RESP holds until rsp_ready.
module dlfloat_mac_host_link
  import dlfloat_pkg::*;
#(
  parameter int WAIT_CYC = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  dlfloat_mac_host_link_if.slave link
);

  link_state_e       state_q, state_d;
  logic              phase_q, phase_d;
  dlf_pair_t         pair_q, pair_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              lo_en;
  logic              hi_en;
  logic              deser_done;
  logic [DLF_W-1:0]  deser_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      pair_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pair_q  <= pair_d;
      cnt_q   <= cnt_d;
    end
  end

  // The phase free-runs so it stays locked to the MAC's own wrappers, which share our reset.
  always_comb begin
    state_d = state_q;
    phase_d = ~phase_q;
    pair_d  = pair_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (link.req_valid && phase_q) begin
          pair_d  = '{a: link.req_a, b: link.req_b};
          state_d = ST_SEND_A;
        end
      end
      ST_SEND_A: state_d = ST_SEND_B;
      ST_SEND_B: begin
        cnt_d   = CNT_W'(WAIT_CYC - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The low byte is sampled on the edge leaving the last phase-1 WAIT cycle.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (phase_q) begin
          state_d = ST_CAP_LO;
        end
      end
      ST_CAP_LO: state_d = ST_CAP_HI;
      ST_CAP_HI: state_d = deser_done ? ST_RESP : ST_IDLE;
      ST_RESP: begin
        if (link.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    link.req_ready = (state_q == ST_IDLE) && phase_q;
    link.rsp_valid = (state_q == ST_RESP);
    link.rsp_data  = (state_q == ST_RESP) ? deser_word : DLF_ZERO;
    link.phase     = phase_q;
    lo_en          = (state_q == ST_WAIT) && (cnt_q == '0) && phase_q;
    hi_en          = (state_q == ST_CAP_LO);
    unique case (state_q)
      ST_SEND_A: link.pin_data = pair_q.a;
      ST_SEND_B: link.pin_data = pair_q.b;
      default:   link.pin_data = DLF_ZERO;
    endcase
  end

  byte_deser u_deser (
    .clk      (clk),
    .rst      (rst),
    .phase    (phase_q),
    .lo_en    (lo_en),
    .hi_en    (hi_en),
    .pin_byte (link.pin_byte),
    .word     (deser_word),
    .done     (deser_done)
  );

endmodule

// File: tb/tb_dlfloat_mac_host_link.sv
// Bench for dlfloat_mac_host_link: scheduled-result MAC byte model plus per-scenario checks of pins, latency and data.
// Model emits junk bytes until the result is due, so early capture corrupts data and late capture shows in latency.
module tb_dlfloat_mac_host_link;
  import dlfloat_pkg::*;

  localparam int WAIT_CYC = 6;
  localparam int EXP_LAT  = WAIT_CYC + 5 + (WAIT_CYC % 2);
  localparam int NEVER    = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dlfloat_mac_host_link_if link();

  dlfloat_mac_host_link #(.WAIT_CYC(WAIT_CYC)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int   cyc   = 0;
  logic tb_ph = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    tb_ph <= rst ? 1'b0 : ~tb_ph;
  end

  // MAC output model: low byte on phase 1, high byte on phase 0, valid from mac_rdy_cyc on.
  logic [15:0] mac_res     = 16'h0000;
  int          mac_rdy_cyc = NEVER;
  logic [7:0]  junk        = 8'h01;
  logic [7:0]  want_byte;
  always @(posedge clk) junk <= 8'($urandom_range(1, 255));
  always_comb begin
    want_byte     = tb_ph ? mac_res[7:0] : mac_res[15:8];
    link.pin_byte = (cyc >= mac_rdy_cyc) ? want_byte : (want_byte ^ junk);
  end

  task automatic wait_accept(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                             output int t, output bit ok, output int waited);
    waited = 0;
    ok     = 1'b0;
    t      = 0;
    link.req_a     = a;
    link.req_b     = b;
    link.req_valid = 1'b1;
    while (!ok && waited < 8) begin
      @(negedge clk);
      if (link.req_ready) begin
        ok          = 1'b1;
        t           = cyc;
        mac_res     = r;
        mac_rdy_cyc = t + 2 + WAIT_CYC;
        tests_run++;
        if (tb_ph !== 1'b1) begin
          tests_failed++;
          $display("FAIL ready_phase got phase=%0b want 1", tb_ph);
        end
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    link.req_valid = 1'b0;
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout got no accept in %0d cycles want accept", waited);
    end
  endtask

  task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                     input int hold, output int waited);
    int          t;
    bit          ok;
    int          lat;
    logic [15:0] exp_pin;
    link.rsp_ready = (hold == 0);
    wait_accept(a, b, r, t, ok, waited);
    if (!ok) return;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat     = cyc - t;
      exp_pin = (lat == 1) ? a : (lat == 2) ? b : 16'h0000;
      tests_run++;
      if (link.pin_data !== exp_pin) begin
        tests_failed++;
        $display("FAIL pin_data lat=%0d got=%h want=%h", lat, link.pin_data, exp_pin);
      end
      if (lat == 1) begin
        tests_run++;
        if (link.phase !== 1'b0) begin
          tests_failed++;
          $display("FAIL send_a_phase got=%0b want=0", link.phase);
        end
      end
      if (link.rsp_valid === 1'b1 || lat >= 40) break;
      @(posedge clk); #1;
    end
    tests_run++;
    if (link.rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsp_timeout got no rsp_valid after %0d cycles want %0d", lat, EXP_LAT);
      return;
    end
    tests_run++;
    if (lat != EXP_LAT) begin
      tests_failed++;
      $display("FAIL latency got=%0d want=%0d", lat, EXP_LAT);
    end
    tests_run++;
    if (link.rsp_data !== r) begin
      tests_failed++;
      $display("FAIL rsp_data got=%h want=%h", link.rsp_data, r);
    end
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (link.rsp_valid !== 1'b1 || link.rsp_data !== r || link.req_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall got valid=%0b data=%h ready=%0b want 1/%h/0",
                   link.rsp_valid, link.rsp_data, link.req_ready, r);
        end
      end
      @(posedge clk); #1;
      link.rsp_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (link.rsp_valid !== 1'b1 || link.rsp_data !== r) begin
        tests_failed++;
        $display("FAIL release got valid=%0b data=%h want 1/%h", link.rsp_valid, link.rsp_data, r);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (link.rsp_valid !== 1'b0 || link.rsp_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rsp_drop got valid=%0b data=%h want 0/0000", link.rsp_valid, link.rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (link.req_ready !== 1'b0 || link.pin_data !== 16'h0000 || link.rsp_valid !== 1'b0 ||
          link.rsp_data !== 16'h0000 || link.phase !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_vals got rdy=%0b pin=%h vld=%0b dat=%h ph=%0b want 0/0000/0/0000/0",
                 link.req_ready, link.pin_data, link.rsp_valid, link.rsp_data, link.phase);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (link.req_ready !== 1'b1 || link.phase !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_rise got rdy=%0b ph=%0b want 1/1", link.req_ready, link.phase);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int w;
    txn(DLF_ONE, 16'h4000, 16'h4000, 0, w);
  endtask

  task automatic test_phase_align();
    int w;
    for (int i = 0; i < 3 && tb_ph !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    txn(16'h3E00, 16'hBE00, 16'hBE00, 0, w);
    tests_run++;
    if (w != 1) begin
      tests_failed++;
      $display("FAIL phase_align got wait=%0d want=1", w);
    end
  endtask

  task automatic test_backpressure();
    int w;
    txn(16'h4100, 16'h3F00, 16'h4280, 5, w);
  endtask

  task automatic test_nan();
    int w;
    txn(DLF_NAN, DLF_ONE, DLF_NAN, 0, w);
  endtask

  task automatic test_random();
    int w;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      txn(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), w);
    end
  endtask

  task automatic test_reset_mid_wait();
    int t;
    bit ok;
    int w;
    bit seen;
    link.rsp_ready = 1'b1;
    wait_accept(16'h3E00, 16'h4000, 16'h4000, t, ok, w);
    if (!ok) return;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst         = 1'b1;
    mac_rdy_cyc = NEVER;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (link.req_ready !== 1'b0 || link.pin_data !== 16'h0000 || link.rsp_valid !== 1'b0 ||
        link.rsp_data !== 16'h0000 || link.phase !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_vals got rdy=%0b pin=%h vld=%0b dat=%h ph=%0b want 0/0000/0/0000/0",
               link.req_ready, link.pin_data, link.rsp_valid, link.rsp_data, link.phase);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (link.rsp_valid === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL no_rsp_after_reset got rsp_valid=1 want 0");
    end
    @(posedge clk); #1;
    txn(DLF_ONE, DLF_ONE, DLF_ONE, 0, w);
  endtask

  initial begin
    link.req_valid = 1'b0;
    link.req_a     = 16'h0000;
    link.req_b     = 16'h0000;
    link.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_phase_align();
    test_backpressure();
    test_nan();
    test_random();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
